src2_dispatch_ctrl: RTL and testbench

//  Issue controller for the shared source-2 operand path. Accepts one operation at a time
//  (ADD/MULT/MULADD), waits until the target execution unit is free, then drives the

---
 rtl/proc_pkg.sv | 38 +++
 rtl/unit_busy_timer.sv | 27 ++
 rtl/src2_dispatch_ctrl.sv | 153 +++++++++++++++
 tb/tb_src2_dispatch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the source-2 dispatch controller: opcodes, FSM states,
// execution-unit indices and the default operand width.
package proc_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_MULT    = 2'b01,
    OP_MULADD  = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  localparam int UNIT_ADD    = 0;
  localparam int UNIT_MULT   = 1;
  localparam int UNIT_MULADD = 2;
  localparam int NUM_UNITS   = 3;

  // Start-pulse vector is ordered {MULADD, MULT, ADD}, matching the opcode value.
  function automatic logic [NUM_UNITS-1:0] op_onehot(input logic [1:0] op);
    logic [NUM_UNITS-1:0] vec;
    vec = '0;
    case (op)
      OP_ADD:    vec[UNIT_ADD]    = 1'b1;
      OP_MULT:   vec[UNIT_MULT]   = 1'b1;
      OP_MULADD: vec[UNIT_MULADD] = 1'b1;
      default:   vec = '0;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/unit_busy_timer.sv
// Occupancy timer for one execution unit: loads LAT on a start, counts down to 0
// and saturates there; busy is high while the count is non-zero.
module unit_busy_timer #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    localparam int CNT_W = $clog2(LAT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LAT);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/src2_dispatch_ctrl.sv
// Issue controller for the shared source-2 operand path (IDLE/HOLD/ISSUE FSM plus
// per-unit busy timers). Optional counters enabled by SRC2_DISPATCH_STATS_EN.
module src2_dispatch_ctrl #(
    parameter int WORD_SIZE  = proc_pkg::WORD_SIZE,
    parameter int ADD_LAT    = 2,
    parameter int MULT_LAT   = 4,
    parameter int MULADD_LAT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_src2,
    output logic [1:0]           source2_sel,
    output logic [WORD_SIZE-1:0] source_2_value,
    output logic [2:0]           issue_start,
    output logic [2:0]           unit_busy,
    output logic                 req_err
`ifdef SRC2_DISPATCH_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          issue_cnt
`endif
);
    import proc_pkg::*;

    state_e                 state;
    state_e                 state_nxt;
    logic [1:0]             op_q;
    logic [WORD_SIZE-1:0]   src2_q;
    logic [1:0]             sel_hold;
    logic [WORD_SIZE-1:0]   val_hold;
    logic                   err_q;
    logic                   xfer;
    logic                   xfer_illegal;
    logic                   xfer_legal;
    logic                   target_busy;
    logic                   issuing;
    logic [NUM_UNITS-1:0]   busy;

    // Handshake: ready is forced low while reset is asserted.
    assign req_ready    = !rst && ((state == ST_IDLE) || (state == ST_ISSUE));
    assign xfer         = req_valid && req_ready;
    assign xfer_illegal = xfer && (req_op == OP_ILLEGAL);
    assign xfer_legal   = xfer && (req_op != OP_ILLEGAL);
    assign issuing      = (state == ST_ISSUE) && !rst;

    always_comb begin
        target_busy = 1'b0;
        case (op_q)
            OP_ADD:    target_busy = busy[UNIT_ADD];
            OP_MULT:   target_busy = busy[UNIT_MULT];
            OP_MULADD: target_busy = busy[UNIT_MULADD];
            default:   target_busy = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; HOLD waits on the registered timer, no same-cycle bypass.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = xfer_legal ? ST_HOLD : ST_IDLE;
            ST_HOLD:  state_nxt = target_busy ? ST_HOLD : ST_ISSUE;
            ST_ISSUE: state_nxt = xfer_legal ? ST_HOLD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: the mux sees the latched request only during ISSUE, else the last issued one.
    always_comb begin
        issue_start    = '0;
        source2_sel    = sel_hold;
        source_2_value = val_hold;
        if (issuing) begin
            issue_start    = op_onehot(op_q);
            source2_sel    = op_q;
            source_2_value = src2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer_legal) begin
            op_q   <= req_op;
            src2_q <= req_src2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_hold <= '0;
            val_hold <= '0;
            err_q    <= 1'b0;
        end else begin
            if (issuing) begin
                sel_hold <= op_q;
                val_hold <= src2_q;
            end
            err_q <= xfer_illegal;
        end
    end

    assign req_err   = err_q;
    assign unit_busy = busy;

    unit_busy_timer #(.LAT(ADD_LAT)) u_add_timer (
        .clk  (clk),
        .rst  (rst),
        .load (issue_start[UNIT_ADD]),
        .busy (busy[UNIT_ADD])
    );

    unit_busy_timer #(.LAT(MULT_LAT)) u_mult_timer (
        .clk  (clk),
        .rst  (rst),
        .load (issue_start[UNIT_MULT]),
        .busy (busy[UNIT_MULT])
    );

    unit_busy_timer #(.LAT(MULADD_LAT)) u_muladd_timer (
        .clk  (clk),
        .rst  (rst),
        .load (issue_start[UNIT_MULADD]),
        .busy (busy[UNIT_MULADD])
    );

`ifdef SRC2_DISPATCH_STATS_EN
    // Stall counter saturates; issue counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if ((state == ST_HOLD) && target_busy && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (issuing) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_src2_dispatch_ctrl.sv
// Directed bench for src2_dispatch_ctrl with hand-computed cycle-by-cycle expectations.
module tb_src2_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_src2 = 32'h0;
    logic [1:0]  source2_sel;
    logic [31:0] source_2_value;
    logic [2:0]  issue_start;
    logic [2:0]  unit_busy;
    logic        req_err;
`ifdef SRC2_DISPATCH_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    src2_dispatch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_src2       (req_src2),
        .source2_sel    (source2_sel),
        .source_2_value (source_2_value),
        .issue_start    (issue_start),
        .unit_busy      (unit_busy),
        .req_err        (req_err)
`ifdef SRC2_DISPATCH_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .issue_cnt      (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d);
        req_valid = v;
        req_op    = op;
        req_src2  = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gap;
        int starts;

        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst_ready", req_ready, 0);
        check("rst_start", issue_start, 0);
        check("rst_busy", unit_busy, 0);
        check("rst_sel", source2_sel, 0);
        check("rst_val", source_2_value, 0);
        check("rst_err", req_err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);

        // ADD accepted at N, start at N+2, busy N+3..N+4
        drive(1, 2'b00, 32'h0000_00AA);
        step();
        check("add_hold_ready", req_ready, 0);
        check("add_hold_start", issue_start, 0);
        drive(0, 2'b00, 32'h0);
        step();
        check("add_start", issue_start, 3'b001);
        check("add_sel", source2_sel, 2'b00);
        check("add_val", source_2_value, 32'hAA);
        check("add_issue_ready", req_ready, 1);
        step();
        check("add_busy1", unit_busy, 3'b001);
        check("add_no_start", issue_start, 0);
        check("add_val_held", source_2_value, 32'hAA);
        step();
        check("add_busy2", unit_busy, 3'b001);
        step();
        check("add_busy_clr", unit_busy, 3'b000);

        // MULT then MULT accepted in the ISSUE cycle: timer 4..1 over S+1..S+4, 0 at S+5, start S+6
        drive(1, 2'b01, 32'h11);
        step();
        drive(0, 2'b00, 32'h0);
        step();
        check("m1_start", issue_start, 3'b010);
        check("m1_sel", source2_sel, 2'b01);
        check("m1_val", source_2_value, 32'h11);
        drive(1, 2'b01, 32'h22);
        step();
        drive(0, 2'b00, 32'h0);
        check("m2_busy", unit_busy, 3'b010);
        check("m2_val_held", source_2_value, 32'h11);
        gap = 1;
        while (issue_start == 3'b000 && gap < 30) begin
            step();
            gap++;
        end
        check("m2_gap", gap, 6);
        check("m2_start", issue_start, 3'b010);
        check("m2_val", source_2_value, 32'h22);
        repeat (6) step();
        check("m2_busy_clr", unit_busy, 3'b000);

        // ADD, MULT, MULADD chained: starts at B+2, B+4, B+6
        drive(1, 2'b00, 32'h1);
        step();
        drive(0, 2'b00, 32'h0);
        check("c_hold_ready", req_ready, 0);
        step();
        check("c_add_start", issue_start, 3'b001);
        drive(1, 2'b01, 32'h2);
        step();
        drive(0, 2'b00, 32'h0);
        check("c_hold_start", issue_start, 0);
        check("c_hold_busy", unit_busy, 3'b001);
        step();
        check("c_mult_start", issue_start, 3'b010);
        check("c_mult_busy", unit_busy, 3'b001);
        check("c_mult_val", source_2_value, 32'h2);
        drive(1, 2'b10, 32'h3);
        step();
        drive(0, 2'b00, 32'h0);
        step();
        check("c_muladd_start", issue_start, 3'b100);
        check("c_muladd_busy", unit_busy, 3'b010);
        check("c_muladd_sel", source2_sel, 2'b10);
        check("c_muladd_val", source_2_value, 32'h3);
        step();
        check("c_busy_overlap", unit_busy, 3'b110);
        check("c_idle_start", issue_start, 0);

        // Illegal opcode from IDLE
        drive(1, 2'b11, 32'hDEAD);
        step();
        drive(0, 2'b00, 32'h0);
        check("ill_err", req_err, 1);
        check("ill_start", issue_start, 0);
        check("ill_ready", req_ready, 1);
        check("ill_val_held", source_2_value, 32'h3);
        step();
        check("ill_err_clr", req_err, 0);
        check("ill_start2", issue_start, 0);

        // MULADD stuck in HOLD behind busy MULADD, then reset
        drive(1, 2'b10, 32'h55);
        step();
        drive(0, 2'b00, 32'h0);
        step();
        check("r_hold_start", issue_start, 0);
        check("r_hold_ready", req_ready, 0);
        check("r_hold_busy", unit_busy, 3'b100);
        rst = 1'b1;
        #1;
        check("r_ready_in_rst", req_ready, 0);
        step();
        check("r_busy", unit_busy, 0);
        check("r_start", issue_start, 0);
        check("r_sel", source2_sel, 0);
        check("r_val", source_2_value, 0);
        check("r_err", req_err, 0);
        rst = 1'b0;
        starts = 0;
        repeat (12) begin
            step();
            if (issue_start != 3'b000) starts++;
        end
        check("r_no_start", starts, 0);
        check("r_ready_after", req_ready, 1);

        // MULT, then second MULT accepted one cycle after the first start: blocked 3 cycles
        drive(1, 2'b01, 32'h7);
        step();
        drive(0, 2'b00, 32'h0);
        step();
        check("g1_start", issue_start, 3'b010);
        step();
        drive(1, 2'b01, 32'h8);
        step();
        drive(0, 2'b00, 32'h0);
        gap = 2;
        while (issue_start == 3'b000 && gap < 30) begin
            step();
            gap++;
        end
        check("g2_gap", gap, 6);
        check("g2_val", source_2_value, 32'h8);
        step();
`ifdef SRC2_DISPATCH_STATS_EN
        check("stat_stall", stall_cnt, 3);
        check("stat_issue", issue_cnt, 2);
`endif
        check("g2_val_held", source_2_value, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
